// File: rtl/wdg_apb4_seq.sv
// wdg_apb4_seq: APB4 master sequencer in front of the watchdog register file.
// Up to NUM_REQ requesters each post one protected operation (FEED, CMP, CTRL
// or PSCR). A round-robin arbiter picks one. The sequencer then issues
// back-to-back APB4 writes: a KEY unlock write before every protected write.
//
// Ports:
//   clk_i, rst_n_i  clock and asynchronous active-low reset
//   req_i           per-requester level request (sampled only in IDLE)
//   op_i            2 bits per requester: 0 FEED, 1 CMP, 2 CTRL, 3 PSCR
//   wdata_i         32 bits per requester (ignored for FEED)
//   gnt_o           one-hot pulse in the first SETUP cycle; op has been captured
//   done_o, err_o   one-hot completion pulse, with error flag (pslverr/timeout)
//   busy_o          high from the grant cycle through the done cycle
//   paddr_o .. pwdata_o, pready_i, pslverr_i   APB4 master (writes only)
//   dbg_state_o     current FSM state (IDLE=0, SETUP=1, ACCESS=2, DONE=3)
//
// Handshake: a requester holds req_i with a stable op_i/wdata_i until it sees
// its gnt_o bit. It then drops req_i within one cycle, or a new request is
// assumed. A transfer completes in an ACCESS cycle where pready_i is 1.
// pslverr_i is only looked at in that cycle.
module wdg_apb4_seq #(
  parameter int          NUM_REQ = 4,
  parameter int          ADDR_W  = 12,
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] KEY_VAL = 32'h5F37_59DF
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [2*NUM_REQ-1:0]  op_i,
  input  logic [32*NUM_REQ-1:0] wdata_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    done_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic [ADDR_W-1:0]     paddr_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [31:0]           pwdata_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  output logic [1:0]            dbg_state_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(12'h000);
  localparam logic [ADDR_W-1:0] A_PSCR = ADDR_W'(12'h004);
  localparam logic [ADDR_W-1:0] A_CMP  = ADDR_W'(12'h00C);
  localparam logic [ADDR_W-1:0] A_KEY  = ADDR_W'(12'h014);
  localparam logic [ADDR_W-1:0] A_FEED = ADDR_W'(12'h018);

  localparam logic [1:0] OP_FEED = 2'd0;
  localparam logic [1:0] OP_CMP  = 2'd1;
  localparam logic [1:0] OP_CTRL = 2'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DONE = 2'd3} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [1:0]    op_q;
  logic [31:0]   wdata_q;
  logic [1:0]    step;
  logic [TW-1:0] tmo_cnt;

  logic [PW-1:0] pick;
  logic          pick_vld;

  assign dbg_state_o = state;
  assign pwrite_o    = psel_o;

  // Even steps are always the KEY unlock. Odd steps are the target write.
  // FEED runs two pairs: FEED=1 then FEED=0, so the counter hold is released.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [1:0] op, input logic [1:0] k);
    if (!k[0]) return A_KEY;
    case (op)
      OP_FEED: return A_FEED;
      OP_CMP:  return A_CMP;
      OP_CTRL: return A_CTRL;
      default: return A_PSCR;
    endcase
  endfunction

  function automatic logic [31:0] step_data(input logic [1:0] op, input logic [1:0] k,
                                            input logic [31:0] wd);
    if (!k[0]) return KEY_VAL;
    if (op == OP_FEED) return {31'd0, ~k[1]};
    return wd;
  endfunction

  // Round-robin: first requesting index at or after ptr, wrapping.
  always_comb begin
    logic [PW:0] sum;
    pick     = '0;
    pick_vld = 1'b0;
    sum      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
      if (!pick_vld && req_i[sum[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = sum[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      op_q      <= '0;
      wdata_q   <= '0;
      step      <= '0;
      tmo_cnt   <= '0;
      gnt_o     <= '0;
      done_o    <= '0;
      err_o     <= 1'b0;
      busy_o    <= 1'b0;
      paddr_o   <= '0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwdata_o  <= '0;
    end else begin
      gnt_o  <= '0;
      done_o <= '0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner     <= pick;
            op_q      <= op_i[{pick, 1'b0} +: 2];
            wdata_q   <= wdata_i[{pick, 5'b0} +: 32];
            step      <= '0;
            gnt_o     <= NUM_REQ'(1) << pick;
            busy_o    <= 1'b1;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            paddr_o   <= A_KEY;
            pwdata_o  <= KEY_VAL;
            state     <= SETUP;
          end
        end
        SETUP: begin
          tmo_cnt   <= '0;
          penable_o <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (pready_i) begin
            if (pslverr_i || step == ((op_q == OP_FEED) ? 2'd3 : 2'd1)) begin
              // A slave error skips whatever steps remain.
              psel_o    <= 1'b0;
              penable_o <= 1'b0;
              done_o    <= NUM_REQ'(1) << owner;
              err_o     <= pslverr_i;
              state     <= DONE;
            end else begin
              step      <= step + 2'd1;
              paddr_o   <= step_addr(op_q, step + 2'd1);
              pwdata_o  <= step_data(op_q, step + 2'd1, wdata_q);
              penable_o <= 1'b0;
              state     <= SETUP;
            end
          end else if (TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            done_o    <= NUM_REQ'(1) << owner;
            err_o     <= 1'b1;
            state     <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: begin // DONE
          busy_o <= 1'b0;
          ptr    <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + PW'(1);
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wdg_apb4_seq.sv
// Bench for wdg_apb4_seq: directed operations. Expected grants, APB writes and
// completions are queued when each op is issued. A negedge monitor pops and
// compares them whenever the DUT presents one.
module tb_wdg_apb4_seq;
  localparam int          NUM_REQ = 4;
  localparam int          ADDR_W  = 12;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] KEY     = 32'h5F37_59DF;
  localparam logic [1:0]  OP_FEED = 2'd0, OP_CMP = 2'd1, OP_CTRL = 2'd2, OP_PSCR = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NUM_REQ-1:0]    req = '0;
  logic [2*NUM_REQ-1:0]  op_v = '0;
  logic [32*NUM_REQ-1:0] wd_v = '0;
  logic [NUM_REQ-1:0]    gnt_o, done_o;
  logic                  err_o, busy_o, psel_o, penable_o, pwrite_o;
  logic [ADDR_W-1:0]     paddr_o;
  logic [31:0]           pwdata_o;
  logic                  pready_i, pslverr_i;
  logic [1:0]            dbg_state_o;

  wdg_apb4_seq #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .KEY_VAL(KEY)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .op_i(op_v), .wdata_i(wd_v),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  logic [ADDR_W+31:0] exp_wr_q[$];
  logic [NUM_REQ-1:0] exp_gnt_q[$];
  logic [NUM_REQ:0]   exp_done_q[$];
  int checks = 0;
  int errors = 0;
  int last_gnt_cyc = 0, last_done_cyc = 0, psel_cycles = 0, acc_cycles = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  function automatic logic [ADDR_W+31:0] exp_step(input logic [1:0] op, input int k,
                                                  input logic [31:0] d);
    if (op == OP_FEED) begin
      case (k)
        0, 2:    return {12'h014, KEY};
        1:       return {12'h018, 32'd1};
        default: return {12'h018, 32'd0};
      endcase
    end
    if (k == 0) return {12'h014, KEY};
    case (op)
      OP_CMP:  return {12'h00C, d};
      OP_CTRL: return {12'h000, d};
      default: return {12'h004, d};
    endcase
  endfunction

  task automatic push_op(input int r, input logic [1:0] op, input logic [31:0] d,
                         input int nwr, input logic err);
    exp_gnt_q.push_back(NUM_REQ'(1) << r);
    for (int k = 0; k < nwr; k++) exp_wr_q.push_back(exp_step(op, k, d));
    exp_done_q.push_back({NUM_REQ'(1) << r, err});
  endtask

  // ---------------- APB slave model ----------------
  int   stall_n = 0;      // pready low for this many ACCESS cycles on KEY writes
  logic stuck = 1'b0;     // pready never returns
  logic err_feed = 1'b0;  // pslverr on the FEED=1 write
  initial begin
    int acc_cnt;
    acc_cnt   = 0;
    pready_i  = 1'b1;
    pslverr_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (psel_o && !penable_o) acc_cnt = 0;
      pready_i  = !(stuck || (psel_o && penable_o && paddr_o == 12'h014 && acc_cnt < stall_n));
      pslverr_i = err_feed && psel_o && penable_o && paddr_o == 12'h018 && pwdata_o == 32'd1;
      if (psel_o && penable_o) acc_cnt++;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (psel_o) psel_cycles++;
        if (psel_o && penable_o) acc_cycles++;
        if (gnt_o != '0) begin
          last_gnt_cyc = cyc;
          if (exp_gnt_q.size() == 0) bad("gnt_unexpected", gnt_o);
          else chk("gnt", gnt_o, exp_gnt_q.pop_front());
        end
        if (psel_o && penable_o) begin
          if (exp_wr_q.size() == 0) bad("apb_unexpected", {paddr_o, pwdata_o});
          else if (pready_i) chk("apb_wr", {pwrite_o, paddr_o, pwdata_o}, {1'b1, exp_wr_q.pop_front()});
          else chk("apb_hold", {pwrite_o, paddr_o, pwdata_o}, {1'b1, exp_wr_q[0]});
        end
        if (done_o != '0) begin
          last_done_cyc = cyc;
          if (exp_done_q.size() == 0) bad("done_unexpected", {done_o, err_o});
          else chk("done_err", {done_o, err_o}, exp_done_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic serve(input int n);
    for (int k = 0; k < n; k++) begin
      int c;
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (gnt_o == '0 && c < 300);
      if (gnt_o == '0) bad("gnt_timeout", req);
      else req = req & ~gnt_o;
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while ((busy_o || exp_done_q.size() != 0) && c < 300);
    if (busy_o || exp_done_q.size() != 0) begin
      bad("idle_timeout", exp_done_q.size());
      exp_done_q.delete();
      exp_gnt_q.delete();
      exp_wr_q.delete();
    end
  endtask

  task automatic run_op(input int r, input logic [1:0] op, input logic [31:0] d,
                        input int nwr, input logic err, input int lat, input string name);
    int n0;
    push_op(r, op, d, nwr, err);
    @(posedge clk);
    #1;
    n0 = cyc;
    op_v[2*r +: 2]  = op;
    wd_v[32*r +: 32] = d;
    req[r] = 1'b1;
    serve(1);
    wait_idle();
    chk({name, "_gnt_lat"}, last_gnt_cyc - n0, 1);
    chk({name, "_done_lat"}, last_done_cyc - n0, lat);
  endtask

  task automatic chk_quiet(input string name);
    chk(name, {gnt_o, done_o, err_o, busy_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
               dbg_state_o}, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0, a0;
    // All four requesters hold req_i from reset: grants 0,1,2,3.
    for (int r = 0; r < NUM_REQ; r++) begin
      op_v[2*r +: 2]   = OP_CMP;
      wd_v[32*r +: 32] = 32'hA0 + r;
      push_op(r, OP_CMP, 32'hA0 + r, 2, 1'b0);
    end
    req = 4'hF;
    #2;
    chk_quiet("reset_outputs");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    serve(4);
    wait_idle();

    // Pointer wrapped to 0: req 0 and 3 together give 0 then 3.
    push_op(0, OP_CMP, 32'h11, 2, 1'b0);
    push_op(3, OP_CTRL, 32'h33, 2, 1'b0);
    op_v[1:0] = OP_CMP;  wd_v[31:0]  = 32'h11;
    op_v[7:6] = OP_CTRL; wd_v[127:96] = 32'h33;
    req = 4'b1001;
    serve(2);
    wait_idle();

    // Single CMP from requester 2.
    run_op(2, OP_CMP, 32'h0000_0100, 2, 1'b0, 5, "cmp");

    // FEED from requester 0: four writes, psel held T1..T8.
    p0 = psel_cycles;
    run_op(0, OP_FEED, 32'hDEAD_BEEF, 4, 1'b0, 9, "feed");
    chk("feed_psel_cycles", psel_cycles - p0, 8);

    // CTRL with 3 wait states on the KEY write.
    stall_n = 3;
    a0 = acc_cycles;
    run_op(1, OP_CTRL, 32'h0000_0005, 2, 1'b0, 8, "stall");
    chk("stall_access_cycles", acc_cycles - a0, 5);
    stall_n = 0;

    // pready stuck low: 16 ACCESS cycles then abort, no further transfer.
    stuck = 1'b1;
    a0 = acc_cycles;
    p0 = psel_cycles;
    run_op(3, OP_PSCR, 32'h0000_0007, 1, 1'b1, 18, "tmo");
    chk("tmo_access_cycles", acc_cycles - a0, 16);
    chk("tmo_psel_cycles", psel_cycles - p0, 17);
    exp_wr_q.delete();
    stuck = 1'b0;

    // pslverr on FEED=1: the last two steps are skipped.
    err_feed = 1'b1;
    run_op(0, OP_FEED, 32'h0, 2, 1'b1, 5, "slverr");
    err_feed = 1'b0;

    // Reset during the second step of a FEED (pointer is 1 at this point).
    exp_gnt_q.push_back(4'b0001);
    exp_wr_q.push_back({12'h014, KEY});
    exp_wr_q.push_back({12'h018, 32'd1});
    @(posedge clk);
    #1;
    op_v[1:0] = OP_FEED;
    req[0] = 1'b1;
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("midop_reset_outputs");
    chk("midop_reset_pending_wr", exp_wr_q.size(), 1);
    chk("midop_reset_pending_gnt", exp_gnt_q.size(), 0);
    exp_wr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_op(0, OP_CMP, 32'h60, 2, 1'b0);
    push_op(2, OP_CMP, 32'h62, 2, 1'b0);
    op_v[1:0] = OP_CMP; wd_v[31:0]  = 32'h60;
    op_v[5:4] = OP_CMP; wd_v[95:64] = 32'h62;
    req = 4'b0101;
    serve(2);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("final_wr_q_empty", exp_wr_q.size(), 0);
    chk("final_gnt_q_empty", exp_gnt_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
